// File: rtl/ram_rr_ctrl.sv
// ram_rr_ctrl: two-requester round-robin front end for an 8x8 single-port RAM.
// It clears the RAM after reset and on request, grants one access per cycle,
// registers the command into the RAM, and tags read returns to their issuer.
//
// Ports:
//   clock, rst_n           clock, asynchronous active-low reset
//   clr                    one-cycle pulse requesting a full RAM clear
//   ready                  high while arbitration is live (RUN)
//   req_x/we_x/addr_x/wdata_x  requester x command, held until granted
//   gnt_x                  combinational grant; transfer on edge with req_x&gnt_x
//   rvalid_x               registered read-return strobe for requester x
//   rdata                  read data (mirror of ram_dout)
//   ram_rst/ram_mode/ram_addr/ram_din  registered RAM command
//   ram_dout               registered RAM read data
module ram_rr_ctrl #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          clr,
  output logic          ready,
  input  logic          req_a,
  input  logic          req_b,
  input  logic          we_a,
  input  logic          we_b,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_a,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          rvalid_a,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata,
  output logic          ram_rst,
  output logic          ram_mode,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {INIT, RUN, DRAIN} state_t;

  state_t state;
  logic   clr_pending;
  logic   last_b;      // 1 = B was granted last, so A wins a tie
  logic   tag_valid;
  logic   tag_read;
  logic   tag_src;     // 0 = A, 1 = B
  logic   xfer;

  assign ready = (state == RUN);
  assign rdata = ram_dout;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (ready) begin
      if (req_a && req_b) begin
        gnt_a = last_b;
        gnt_b = ~last_b;
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  assign xfer = gnt_a | gnt_b;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INIT;
      clr_pending <= 1'b0;
      last_b      <= 1'b1;
      ram_rst     <= 1'b1;
      ram_mode    <= 1'b1;
      ram_addr    <= '0;
      ram_din     <= '0;
      tag_valid   <= 1'b0;
      tag_read    <= 1'b0;
      tag_src     <= 1'b0;
      rvalid_a    <= 1'b0;
      rvalid_b    <= 1'b0;
    end else begin
      // Command stage: only a granted transfer may drive mode=0 (write).
      if (xfer) begin
        ram_addr  <= gnt_b ? addr_b  : addr_a;
        ram_din   <= gnt_b ? wdata_b : wdata_a;
        ram_mode  <= ~(gnt_b ? we_b : we_a);
        tag_valid <= 1'b1;
        tag_read  <= ~(gnt_b ? we_b : we_a);
        tag_src   <= gnt_b;
        last_b    <= gnt_b;
      end else begin
        ram_mode  <= 1'b1;
        tag_valid <= 1'b0;
        tag_read  <= 1'b0;
        tag_src   <= 1'b0;
      end

      // Return stage: lines up with the RAM's registered dout.
      rvalid_a <= tag_valid & tag_read & ~tag_src;
      rvalid_b <= tag_valid & tag_read &  tag_src;

      case (state)
        INIT: begin
          state       <= RUN;
          ram_rst     <= 1'b0;
          clr_pending <= clr_pending | clr;
        end
        RUN: begin
          // The grant in the clr cycle is still honoured; the pass it
          // starts consumes any pending request.
          if (clr || clr_pending) begin
            state       <= DRAIN;
            clr_pending <= 1'b0;
          end
        end
        DRAIN: begin
          clr_pending <= clr_pending | clr;
          // The return stage is fed only by the command stage, so once the
          // command stage is empty the return stage empties on this same edge.
          if (!tag_valid) begin
            state   <= INIT;
            ram_rst <= 1'b1;
          end
        end
        default: begin
          state   <= INIT;
          ram_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule
